// File: rtl/branch_resolve_unit.sv
// Multi-lane branch resolution: oldest-event selection, registered link/redirect/exception outputs
// and a predictor-update FIFO. Define BRU_PERF_COUNTERS_EN to add branch/mispredict counters.
module branch_resolve_unit #(
    parameter int NrPorts     = 2,
    parameter int VLEN        = 64,
    parameter int TransIdBits = 3,
    parameter int QueueDepth  = 4,
    parameter int RVC         = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           flush_i,
    input  logic [NrPorts-1:0]             valid_i,
    output logic                           ready_o,
    input  logic [NrPorts*2-1:0]           op_i,
    input  logic [NrPorts*VLEN-1:0]        pc_i,
    input  logic [NrPorts*VLEN-1:0]        operand_a_i,
    input  logic [NrPorts*VLEN-1:0]        imm_i,
    input  logic [NrPorts-1:0]             is_compressed_i,
    input  logic [NrPorts-1:0]             comp_res_i,
    input  logic [NrPorts*3-1:0]           pred_cf_i,
    input  logic [NrPorts*VLEN-1:0]        pred_addr_i,
    input  logic [NrPorts*TransIdBits-1:0] trans_id_i,
    output logic [NrPorts-1:0]             result_valid_o,
    output logic [NrPorts*VLEN-1:0]        result_o,
    output logic [NrPorts*TransIdBits-1:0] result_id_o,
    output logic                           redirect_valid_o,
    output logic [VLEN-1:0]                redirect_pc_o,
    output logic                           ex_valid_o,
    output logic [VLEN-1:0]                ex_tval_o,
    output logic [TransIdBits-1:0]         ex_id_o,
    output logic                           upd_valid_o,
    input  logic                           upd_ready_i,
    output logic [VLEN-1:0]                upd_pc_o,
    output logic [VLEN-1:0]                upd_target_o,
    output logic                           upd_taken_o,
    output logic [2:0]                     upd_cf_o
`ifdef BRU_PERF_COUNTERS_EN
    ,
    output logic [31:0]                    perf_branches_o,
    output logic [31:0]                    perf_mispredicts_o
`endif
);
    localparam int PtrW = (QueueDepth > 1) ? $clog2(QueueDepth) : 1;
    localparam int CntW = PtrW + 1;

    typedef enum logic {StRun, StWaitFlush} state_e;

    state_e                            state_q;
    logic [CntW-1:0]                   count_q;
    logic [PtrW-1:0]                   wrPtr_q, rdPtr_q;
    logic [VLEN-1:0]                   pcMem_q     [QueueDepth];
    logic [VLEN-1:0]                   targetMem_q [QueueDepth];
    logic                              takenMem_q  [QueueDepth];
    logic [2:0]                        cfMem_q     [QueueDepth];

    logic [NrPorts-1:0]                resultValid_q;
    logic [NrPorts-1:0][VLEN-1:0]      result_q;
    logic [NrPorts-1:0][TransIdBits-1:0] resultId_q;
    logic                              redirectValid_q, exValid_q;
    logic [VLEN-1:0]                   redirectPc_q, exTval_q;
    logic [TransIdBits-1:0]            exId_q;

    logic [NrPorts-1:0][VLEN-1:0]      laneTarget, laneNext;
    logic [NrPorts-1:0][2:0]           laneCf;
    logic [NrPorts-1:0]                laneTaken, laneMisp, laneExc;

    for (genvar g = 0; g < NrPorts; g++) begin : gen_lane
        logic [1:0]      op;
        logic [2:0]      predCf;
        logic [VLEN-1:0] pc, sum;
        logic            isBranch, isJalr;

        assign op       = op_i[2*g +: 2];
        assign predCf   = pred_cf_i[3*g +: 3];
        assign pc       = pc_i[VLEN*g +: VLEN];
        assign isBranch = (op == 2'd0);
        assign isJalr   = (op == 2'd2);
        assign sum      = (isJalr ? operand_a_i[VLEN*g +: VLEN] : pc) + imm_i[VLEN*g +: VLEN];

        assign laneTarget[g] = {sum[VLEN-1:1], sum[0] & ~isJalr};
        assign laneNext[g]   = pc + (is_compressed_i[g] ? VLEN'(2) : VLEN'(4));
        assign laneTaken[g]  = isBranch ? comp_res_i[g] : 1'b1;
        assign laneMisp[g]   = isBranch ? (comp_res_i[g] != (predCf == 3'd1))
                             : isJalr   ? ((predCf == 3'd0) || (laneTarget[g] != pred_addr_i[VLEN*g +: VLEN]))
                             : 1'b0;
        assign laneExc[g]    = (RVC == 0) && laneTaken[g] && (laneTarget[g][1:0] != 2'b00);
        // A mispredicted JALR keeps the Return hint so the RAS stays coherent.
        assign laneCf[g]     = isBranch     ? 3'd1
                             : !isJalr      ? 3'd2
                             : !laneMisp[g] ? predCf
                             : (predCf == 3'd4) ? 3'd4 : 3'd3;
    end

    logic                          ready, empty, pop, eventSeen;
    logic                          winRedirect, winExc;
    logic [VLEN-1:0]               winRedirectPc, winTval;
    logic [TransIdBits-1:0]        winExId;
    logic [NrPorts-1:0]            live, push;
    logic [NrPorts-1:0][PtrW-1:0]  slot;
    logic [CntW-1:0]               pushCnt;

    assign empty = (count_q == '0);
    assign pop   = !empty && upd_ready_i;
    assign ready = (state_q == StRun) && ((CntW'(QueueDepth) - count_q) >= CntW'(NrPorts));
    assign push  = live & ~laneExc;

    // Walk lanes oldest first; the first event stops every younger lane.
    always_comb begin
        eventSeen     = 1'b0;
        live          = '0;
        slot          = '0;
        pushCnt       = '0;
        winRedirect   = 1'b0;
        winRedirectPc = '0;
        winExc        = 1'b0;
        winTval       = '0;
        winExId       = '0;
        for (int i = 0; i < NrPorts; i++) begin
            slot[i] = wrPtr_q + pushCnt[PtrW-1:0];
            if (valid_i[i] && ready && !eventSeen) begin
                live[i] = 1'b1;
                if (laneExc[i]) begin
                    eventSeen = 1'b1;
                    winExc    = 1'b1;
                    winTval   = pc_i[VLEN*i +: VLEN];
                    winExId   = trans_id_i[TransIdBits*i +: TransIdBits];
                end else begin
                    pushCnt = pushCnt + CntW'(1);
                    if (laneMisp[i]) begin
                        eventSeen     = 1'b1;
                        winRedirect   = 1'b1;
                        winRedirectPc = laneTaken[i] ? laneTarget[i] : laneNext[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= StRun;
            count_q         <= '0;
            wrPtr_q         <= '0;
            rdPtr_q         <= '0;
            resultValid_q   <= '0;
            result_q        <= '0;
            resultId_q      <= '0;
            redirectValid_q <= 1'b0;
            redirectPc_q    <= '0;
            exValid_q       <= 1'b0;
            exTval_q        <= '0;
            exId_q          <= '0;
        end else begin
            count_q <= count_q + pushCnt - CntW'(pop);
            wrPtr_q <= wrPtr_q + pushCnt[PtrW-1:0];
            rdPtr_q <= rdPtr_q + PtrW'(pop);
            for (int i = 0; i < NrPorts; i++) begin
                if (push[i]) begin
                    pcMem_q[slot[i]]     <= pc_i[VLEN*i +: VLEN];
                    targetMem_q[slot[i]] <= laneTarget[i];
                    takenMem_q[slot[i]]  <= laneTaken[i];
                    cfMem_q[slot[i]]     <= laneCf[i];
                end
            end
            // Flush clears the output stage but leaves queued predictor updates intact.
            if (flush_i) begin
                state_q         <= StRun;
                resultValid_q   <= '0;
                result_q        <= '0;
                resultId_q      <= '0;
                redirectValid_q <= 1'b0;
                redirectPc_q    <= '0;
                exValid_q       <= 1'b0;
                exTval_q        <= '0;
                exId_q          <= '0;
            end else begin
                if ((state_q == StRun) && eventSeen) state_q <= StWaitFlush;
                for (int i = 0; i < NrPorts; i++) begin
                    resultValid_q[i] <= push[i];
                    result_q[i]      <= push[i] ? laneNext[i] : '0;
                    resultId_q[i]    <= push[i] ? trans_id_i[TransIdBits*i +: TransIdBits] : '0;
                end
                redirectValid_q <= winRedirect;
                redirectPc_q    <= winRedirectPc;
                exValid_q       <= winExc;
                exTval_q        <= winTval;
                exId_q          <= winExId;
            end
        end
    end

    assign ready_o          = ready;
    assign result_valid_o   = resultValid_q;
    assign result_o         = result_q;
    assign result_id_o      = resultId_q;
    assign redirect_valid_o = redirectValid_q;
    assign redirect_pc_o    = redirectPc_q;
    assign ex_valid_o       = exValid_q;
    assign ex_tval_o        = exTval_q;
    assign ex_id_o          = exId_q;
    assign upd_valid_o      = !empty;
    assign upd_pc_o         = empty ? '0 : pcMem_q[rdPtr_q];
    assign upd_target_o     = empty ? '0 : targetMem_q[rdPtr_q];
    assign upd_taken_o      = empty ? 1'b0 : takenMem_q[rdPtr_q];
    assign upd_cf_o         = empty ? 3'd0 : cfMem_q[rdPtr_q];

`ifdef BRU_PERF_COUNTERS_EN
    logic [31:0] perfBranches_q, perfMispredicts_q;
    logic [32:0] branchSum;

    always_comb begin
        branchSum = {1'b0, perfBranches_q};
        for (int i = 0; i < NrPorts; i++) begin
            if (live[i] && (op_i[2*i +: 2] == 2'd0)) branchSum = branchSum + 33'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perfBranches_q    <= '0;
            perfMispredicts_q <= '0;
        end else begin
            perfBranches_q <= branchSum[32] ? '1 : branchSum[31:0];
            if (winRedirect && (perfMispredicts_q != '1)) perfMispredicts_q <= perfMispredicts_q + 32'd1;
        end
    end

    assign perf_branches_o    = perfBranches_q;
    assign perf_mispredicts_o = perfMispredicts_q;
`else
    // Performance counters are compiled out of this build.
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomised bench for branch_resolve_unit (2 lanes, RVC=0) against a queue-based reference model.
module tb_branch_resolve_unit;
    localparam int NP = 2;
    localparam int QD = 4;

    logic         clk = 1'b0;
    logic         rst, flush, updReady;
    logic [1:0]   validIn, iscIn, compIn;
    logic [3:0]   opIn;
    logic [127:0] pcIn, opaIn, immIn, paddrIn;
    logic [5:0]   pcfIn, tidIn;

    logic         ready, redirectValid, exValid, updValid, updTaken;
    logic [1:0]   resultValid;
    logic [127:0] result;
    logic [5:0]   resultId;
    logic [63:0]  redirectPc, exTval, updPc, updTarget;
    logic [2:0]   exId, updCf;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] target;
        logic        taken;
        logic [2:0]  cf;
    } updEntry_t;

    updEntry_t   updQ[$];
    bit          mWait;
    logic [1:0]  expResValid;
    logic [63:0] expRes [NP];
    logic [2:0]  expResId [NP];
    logic        expRedir, expEx;
    logic [63:0] expRedirPc, expTval;
    logic [2:0]  expExId;

    int checks = 0;
    int errors = 0;

    branch_resolve_unit #(
        .NrPorts(2), .VLEN(64), .TransIdBits(3), .QueueDepth(4), .RVC(0)
    ) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(validIn), .ready_o(ready),
        .op_i(opIn), .pc_i(pcIn), .operand_a_i(opaIn), .imm_i(immIn),
        .is_compressed_i(iscIn), .comp_res_i(compIn), .pred_cf_i(pcfIn),
        .pred_addr_i(paddrIn), .trans_id_i(tidIn),
        .result_valid_o(resultValid), .result_o(result), .result_id_o(resultId),
        .redirect_valid_o(redirectValid), .redirect_pc_o(redirectPc),
        .ex_valid_o(exValid), .ex_tval_o(exTval), .ex_id_o(exId),
        .upd_valid_o(updValid), .upd_ready_i(updReady), .upd_pc_o(updPc),
        .upd_target_o(updTarget), .upd_taken_o(updTaken), .upd_cf_o(updCf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] modelTarget(input logic [1:0] o, input logic [63:0] p,
                                                input logic [63:0] a, input logic [63:0] im);
        logic [63:0] t;
        t = ((o == 2'd2) ? a : p) + im;
        if (o == 2'd2) t[0] = 1'b0;
        return t;
    endfunction

    task automatic clearExp();
        expResValid = '0;
        expRedir = 1'b0; expRedirPc = '0;
        expEx = 1'b0; expTval = '0; expExId = '0;
        for (int l = 0; l < NP; l++) begin
            expRes[l] = '0;
            expResId[l] = '0;
        end
    endtask

    // Reference: evaluates the resolution rules lane by lane and tracks the FIFO as a queue.
    task automatic modelStep();
        bit          canAccept, stop, popNow;
        logic [1:0]  op;
        logic [2:0]  pcf, cf;
        logic [63:0] pcv, tgt, nxt;
        bit          taken, misp, exc;
        updEntry_t   e;
        updEntry_t   newEntries[$];
        if (rst) begin
            mWait = 1'b0;
            updQ.delete();
            clearExp();
            return;
        end
        canAccept = !mWait && ((QD - updQ.size()) >= NP);
        popNow = (updQ.size() != 0) && updReady;
        clearExp();
        stop = 1'b0;
        if (canAccept) begin
            for (int l = 0; l < NP; l++) begin
                if (!validIn[l] || stop) continue;
                op    = opIn[2*l +: 2];
                pcf   = pcfIn[3*l +: 3];
                pcv   = pcIn[64*l +: 64];
                tgt   = modelTarget(op, pcv, opaIn[64*l +: 64], immIn[64*l +: 64]);
                nxt   = pcv + (iscIn[l] ? 64'd2 : 64'd4);
                taken = (op == 2'd0) ? compIn[l] : 1'b1;
                if (op == 2'd0)      misp = (taken != (pcf == 3'd1));
                else if (op == 2'd2) misp = (pcf == 3'd0) || (tgt != paddrIn[64*l +: 64]);
                else                 misp = 1'b0;
                exc = taken && (tgt[1:0] != 2'b00);
                if (op == 2'd0)      cf = 3'd1;
                else if (op != 2'd2) cf = 3'd2;
                else if (!misp)      cf = pcf;
                else                 cf = (pcf == 3'd4) ? 3'd4 : 3'd3;
                if (exc) begin
                    expEx = 1'b1; expTval = pcv; expExId = tidIn[3*l +: 3];
                    stop = 1'b1;
                end else begin
                    expResValid[l] = 1'b1;
                    expRes[l] = nxt;
                    expResId[l] = tidIn[3*l +: 3];
                    e.pc = pcv; e.target = tgt; e.taken = taken; e.cf = cf;
                    newEntries.push_back(e);
                    if (misp) begin
                        expRedir = 1'b1;
                        expRedirPc = taken ? tgt : nxt;
                        stop = 1'b1;
                    end
                end
            end
        end
        if (popNow) void'(updQ.pop_front());
        foreach (newEntries[k]) updQ.push_back(newEntries[k]);
        if (flush) begin
            mWait = 1'b0;
            clearExp();
        end else if (stop) begin
            mWait = 1'b1;
        end
    endtask

    task automatic checkOutput();
        check("ready", 64'(ready), 64'(!mWait && ((QD - updQ.size()) >= NP)));
        for (int l = 0; l < NP; l++) begin
            check($sformatf("resultValid%0d", l), 64'(resultValid[l]), 64'(expResValid[l]));
            check($sformatf("result%0d", l), result[64*l +: 64], expRes[l]);
            check($sformatf("resultId%0d", l), 64'(resultId[3*l +: 3]), 64'(expResId[l]));
        end
        check("redirectValid", 64'(redirectValid), 64'(expRedir));
        check("redirectPc", redirectPc, expRedirPc);
        check("exValid", 64'(exValid), 64'(expEx));
        check("exTval", exTval, expTval);
        check("exId", 64'(exId), 64'(expExId));
        check("updValid", 64'(updValid), 64'(updQ.size() != 0));
        if (updQ.size() != 0) begin
            check("updPc", updPc, updQ[0].pc);
            check("updTarget", updTarget, updQ[0].target);
            check("updTaken", 64'(updTaken), 64'(updQ[0].taken));
            check("updCf", 64'(updCf), 64'(updQ[0].cf));
        end
    endtask

    // One clock: model predicts, DUT clocks, outputs compared at the following negedge.
    task automatic applyStimulus();
        modelStep();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic clearLanes();
        validIn = '0; opIn = '0; pcIn = '0; opaIn = '0; immIn = '0;
        iscIn = '0; compIn = '0; pcfIn = '0; paddrIn = '0; tidIn = '0;
    endtask

    task automatic setLane(input int l, input logic [1:0] o, input logic [63:0] p,
                           input logic [63:0] a, input logic [63:0] im, input logic c,
                           input logic cr, input logic [2:0] pf, input logic [63:0] pa,
                           input logic [2:0] id);
        validIn[l] = 1'b1;
        opIn[2*l +: 2] = o;
        pcIn[64*l +: 64] = p;
        opaIn[64*l +: 64] = a;
        immIn[64*l +: 64] = im;
        iscIn[l] = c;
        compIn[l] = cr;
        pcfIn[3*l +: 3] = pf;
        paddrIn[64*l +: 64] = pa;
        tidIn[3*l +: 3] = id;
    endtask

    task automatic randomLanes();
        logic [1:0]  o;
        logic [63:0] p, a, im, pa;
        int          s;
        clearLanes();
        for (int l = 0; l < NP; l++) begin
            o = 2'($urandom_range(0, 3));
            p = {$urandom, $urandom};
            p[1:0] = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
            a = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            s = int'($urandom_range(0, 511)) - 256;
            im = 64'(s);
            if ($urandom_range(0, 3) != 0) im[1:0] = 2'b00;
            pa = ($urandom_range(0, 1) == 1) ? modelTarget(o, p, a, im) : {$urandom, $urandom};
            setLane(l, o, p, a, im, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 4)), pa, 3'($urandom_range(0, 7)));
            validIn[l] = ($urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; updReady = 1'b0;
        clearLanes();
        clearExp();
        @(negedge clk);
        applyStimulus();
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_updValid", 64'(updValid), 64'd0);
        rst = 1'b0;

        // Correctly predicted taken branch: link result, no redirect, one FIFO entry.
        setLane(0, 2'd0, 64'h1000, 64'h0, 64'h40, 1'b0, 1'b1, 3'd1, 64'h0, 3'd1);
        applyStimulus();
        check("t1_result0", result[63:0], 64'h1004);
        check("t1_redirect", 64'(redirectValid), 64'd0);
        check("t1_updTarget", updTarget, 64'h1040);
        check("t1_updCf", 64'(updCf), 64'd1);
        clearLanes(); updReady = 1'b1;
        applyStimulus();

        // JALR mispredict on lane 0 kills the JAL on lane 1.
        setLane(0, 2'd2, 64'h1100, 64'h2001, 64'h10, 1'b0, 1'b0, 3'd0, 64'h0, 3'd1);
        setLane(1, 2'd1, 64'h1104, 64'h0, 64'h8, 1'b0, 1'b0, 3'd2, 64'h0, 3'd2);
        applyStimulus();
        check("t2_redirectPc", redirectPc, 64'h2010);
        check("t2_resultValid", 64'(resultValid), 64'b01);
        check("t2_ready", 64'(ready), 64'd0);
        applyStimulus();
        check("t2_readyHeld", 64'(ready), 64'd0);
        clearLanes(); flush = 1'b1;
        applyStimulus();
        check("t2_readyFlush", 64'(ready), 64'd1);
        flush = 1'b0;

        // Misaligned JAL target on lane 1 raises the exception; lane 0 still retires.
        setLane(0, 2'd0, 64'h2FFC, 64'h0, 64'h20, 1'b0, 1'b0, 3'd0, 64'h0, 3'd4);
        setLane(1, 2'd1, 64'h3000, 64'h0, 64'h6, 1'b0, 1'b0, 3'd2, 64'h0, 3'd5);
        applyStimulus();
        check("t3_exValid", 64'(exValid), 64'd1);
        check("t3_exTval", exTval, 64'h3000);
        check("t3_exId", 64'(exId), 64'd5);
        check("t3_result0", result[63:0], 64'h3000);
        clearLanes(); flush = 1'b1;
        applyStimulus();
        flush = 1'b0;
        applyStimulus();

        // Fill the FIFO with backpressure, pop twice, refill across the pointer wrap, drain.
        updReady = 1'b0;
        setLane(0, 2'd0, 64'h4000, 64'h0, 64'h40, 1'b0, 1'b1, 3'd1, 64'h0, 3'd0);
        setLane(1, 2'd0, 64'h4004, 64'h0, 64'h40, 1'b0, 1'b1, 3'd1, 64'h0, 3'd1);
        applyStimulus();
        check("t4_readyHalf", 64'(ready), 64'd1);
        setLane(0, 2'd0, 64'h4100, 64'h0, 64'h40, 1'b0, 1'b1, 3'd1, 64'h0, 3'd2);
        setLane(1, 2'd0, 64'h4104, 64'h0, 64'h40, 1'b0, 1'b1, 3'd1, 64'h0, 3'd3);
        applyStimulus();
        check("t4_readyFull", 64'(ready), 64'd0);
        clearLanes(); updReady = 1'b1;
        applyStimulus();
        check("t4_readyPop1", 64'(ready), 64'd0);
        applyStimulus();
        check("t4_readyPop2", 64'(ready), 64'd1);
        check("t4_headB", updPc, 64'h4100);
        updReady = 1'b0;
        setLane(0, 2'd1, 64'h4200, 64'h0, 64'h40, 1'b0, 1'b0, 3'd2, 64'h0, 3'd4);
        setLane(1, 2'd1, 64'h4204, 64'h0, 64'h40, 1'b0, 1'b0, 3'd2, 64'h0, 3'd5);
        applyStimulus();
        clearLanes(); updReady = 1'b1;
        applyStimulus();
        check("t4_head2", updPc, 64'h4104);
        applyStimulus();
        check("t4_head3", updPc, 64'h4200);
        applyStimulus();
        check("t4_head4", updPc, 64'h4204);
        applyStimulus();
        check("t4_empty", 64'(updValid), 64'd0);

        // Compressed not-taken branch at the top of the address space: next PC wraps to 0.
        setLane(0, 2'd0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 64'h10, 1'b1, 1'b0, 3'd1, 64'h0, 3'd6);
        applyStimulus();
        check("t5_redirect", 64'(redirectValid), 64'd1);
        check("t5_redirectPc", redirectPc, 64'h0);
        clearLanes(); flush = 1'b1;
        applyStimulus();
        flush = 1'b0;
        applyStimulus();

        // Reset while waiting for flush with three queued updates.
        updReady = 1'b0;
        setLane(0, 2'd0, 64'h5000, 64'h0, 64'h40, 1'b0, 1'b1, 3'd1, 64'h0, 3'd1);
        setLane(1, 2'd0, 64'h5004, 64'h0, 64'h40, 1'b0, 1'b1, 3'd1, 64'h0, 3'd2);
        applyStimulus();
        clearLanes();
        setLane(0, 2'd0, 64'h5100, 64'h0, 64'h40, 1'b0, 1'b1, 3'd0, 64'h0, 3'd3);
        applyStimulus();
        check("t6_ready", 64'(ready), 64'd0);
        check("t6_updValid", 64'(updValid), 64'd1);
        clearLanes(); rst = 1'b1;
        applyStimulus();
        check("t6_rstUpdValid", 64'(updValid), 64'd0);
        check("t6_rstReady", 64'(ready), 64'd1);
        check("t6_rstResultValid", 64'(resultValid), 64'd0);
        check("t6_rstRedirect", 64'(redirectValid), 64'd0);
        check("t6_rstUpdPc", updPc, 64'h0);
        rst = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            updReady = ($urandom_range(0, 9) < 6);
            randomLanes();
            if (mWait) begin
                flush = ($urandom_range(0, 2) == 0);
            end else begin
                flush = ($urandom_range(0, 19) == 0);
                if (flush) validIn = '0;
            end
            applyStimulus();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
